// File: rtl/pc_sequencer_if.sv
// Port bundle between the PC sequencer, its halt detector and the test harness.
interface pc_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 6,
  parameter int CNT_W = 16
);
  logic             start;
  logic [PC_W-1:0]  prog_end;
  logic             halt;
  logic             stall;
  logic             jump_en;
  logic [PC_W-1:0]  jump_target;
  logic             branch_taken;
  logic [OFF_W-1:0] branch_offset;
  logic [PC_W-1:0]  pc_curr;
  logic [PC_W-1:0]  pc_end;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  // Sequencer side: consumes control, produces PC and status.
  modport master (
    input  start, prog_end, halt, stall, jump_en, jump_target,
           branch_taken, branch_offset,
    output pc_curr, pc_end, running, done, cycle_count
  );

  // Harness / halt-detector side.
  modport slave (
    output start, prog_end, halt, stall, jump_en, jump_target,
           branch_taken, branch_offset,
    input  pc_curr, pc_end, running, done, cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: start/stall/jump/branch PC update, halt freeze, cycle count.
// Latency: start -> running 1 cycle; halt -> done pulse 1 cycle.
// Backpressure: stall holds the PC and the cycle counter; halt freezes until the next start.
module pc_sequencer #(
  parameter int              PC_W       = 8,
  parameter int              OFF_W      = 6,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic [PC_W-1:0]  end_q, end_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             done_q, done_nxt;
  logic             advance;
  logic [PC_W-1:0]  off_ext;

  assign off_ext = {{(PC_W-OFF_W){bus.branch_offset[OFF_W-1]}}, bus.branch_offset};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc_q   <= START_ADDR;
      end_q  <= '1;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      end_q  <= end_nxt;
      cnt_q  <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    end_nxt   = end_q;
    cnt_nxt   = cnt_q;
    done_nxt  = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (bus.start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
          end_nxt   = bus.prog_end;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        // halt is seen the same cycle pc reaches the end PC, so that PC never advances
        if (bus.halt) begin
          state_nxt = HALTED;
          done_nxt  = 1'b1;
        end else if (!bus.stall) begin
          advance = 1'b1;
          if (bus.jump_en)           pc_nxt = bus.jump_target;
          else if (bus.branch_taken) pc_nxt = pc_q + off_ext;
          else                       pc_nxt = pc_q + PC_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (advance && (cnt_q != {CNT_W{1'b1}})) cnt_nxt = cnt_q + CNT_W'(1);
  end

  assign bus.pc_curr     = pc_q;
  assign bus.pc_end      = end_q;
  assign bus.running     = (state == RUN);
  assign bus.done        = done_q;
  assign bus.cycle_count = cnt_q;

endmodule
